// File: rtl/dda_run_ctrl_if.sv
// Command word channel from the SPI word receiver into the DDA run controller.
interface dda_run_ctrl_if;
  logic        cmd_valid;
  logic [31:0] cmd_word;   // {opcode[31:28], arg[27:16], data[15:0]}
  logic        cmd_ready;

  modport master (output cmd_valid, output cmd_word, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_word, output cmd_ready);
endinterface

// File: rtl/dda_run_ctrl.sv
// Run controller for the posit Van der Pol DDA: holds mu/icx/icy, issues
// load and rate-divided step pulses, and snapshots x/y for read-back.
module dda_run_ctrl #(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 12,
  parameter int unsigned DIV_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dda_run_ctrl_if.slave        cmd,
  input  logic [N-1:0]         x,
  input  logic [N-1:0]         y,
  output logic [N-1:0]         mu,
  output logic [N-1:0]         icx,
  output logic [N-1:0]         icy,
  output logic                 dda_load,
  output logic                 dda_step,
  output logic [N-1:0]         x_snap,
  output logic [N-1:0]         y_snap,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     steps_left
);

  localparam logic [N-1:0] PARAM_RST = N'(16'h3000);

  localparam logic [3:0] OP_WR_MU  = 4'h1;
  localparam logic [3:0] OP_WR_ICX = 4'h2;
  localparam logic [3:0] OP_WR_ICY = 4'h3;
  localparam logic [3:0] OP_LOAD   = 4'h4;
  localparam logic [3:0] OP_RUN    = 4'h5;
  localparam logic [3:0] OP_STOP   = 4'h6;
  localparam logic [3:0] OP_WR_DIV = 4'h7;
  localparam logic [3:0] OP_SNAP   = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_presc;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_left;
  logic [N-1:0]      r_mu;
  logic [N-1:0]      r_icx;
  logic [N-1:0]      r_icy;
  logic [N-1:0]      r_x_snap;
  logic [N-1:0]      r_y_snap;
  logic              r_load;
  logic              r_step;
  logic              r_busy;
  logic              r_done;
  logic              r_ready;

  logic              w_accept;
  logic [3:0]        w_op;
  logic [11:0]       w_arg;
  logic [15:0]       w_data;
  logic              w_last;
  state_t            w_state_n;
  logic [DIV_W-1:0]  w_presc_n;
  logic [DIV_W-1:0]  w_div_n;
  logic [CNT_W-1:0]  w_left_n;
  logic              w_done_n;
  logic              w_snap_n;

  // Command field decode and handshake.
  assign w_accept = cmd.cmd_valid && r_ready;
  assign w_op     = cmd.cmd_word[31:28];
  assign w_arg    = cmd.cmd_word[27:16];
  assign w_data   = cmd.cmd_word[15:0];

  // The step pulsing this cycle is the final one of a bounded run.
  assign w_last = (r_state == ST_RUN) && r_step && (r_left == CNT_W'(1));

  // Next-state, prescaler and step-count update; completion beats STOP,
  // while a fresh RUN restarts the run even on its final step.
  always_comb begin
    w_state_n = r_state;
    w_presc_n = r_presc;
    w_div_n   = r_div;
    w_left_n  = r_left;
    w_done_n  = 1'b0;

    case (r_state)
      ST_LOADING: w_state_n = ST_IDLE;
      ST_RUN: begin
        if (r_step) begin
          w_presc_n = '0;
          if (r_left != '0) begin
            w_left_n = r_left - CNT_W'(1);
          end
        end else begin
          w_presc_n = r_presc + DIV_W'(1);
        end
        if (w_last) begin
          w_state_n = ST_IDLE;
          w_done_n  = 1'b1;
        end
      end
      default: ;
    endcase

    if (w_accept) begin
      case (w_op)
        OP_WR_DIV: w_div_n = DIV_W'(w_data);
        OP_LOAD: begin
          if (r_state == ST_IDLE) begin
            w_state_n = ST_LOADING;
          end
        end
        OP_RUN: begin
          w_state_n = ST_RUN;
          w_presc_n = '0;
          w_left_n  = CNT_W'(w_arg);
          w_done_n  = 1'b0;
        end
        OP_STOP: begin
          if ((r_state == ST_RUN) && !w_last) begin
            w_state_n = ST_IDLE;
            w_presc_n = '0;
            w_left_n  = '0;
          end
        end
        default: ;
      endcase
    end

    w_snap_n = w_done_n || (w_accept && (w_op == OP_SNAP));
  end

  // State, parameter registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_presc  <= '0;
      r_div    <= '0;
      r_left   <= '0;
      r_mu     <= PARAM_RST;
      r_icx    <= PARAM_RST;
      r_icy    <= PARAM_RST;
      r_x_snap <= '0;
      r_y_snap <= '0;
      r_load   <= 1'b0;
      r_step   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_presc <= w_presc_n;
      r_div   <= w_div_n;
      r_left  <= w_left_n;
      r_load  <= (w_state_n == ST_LOADING);
      r_ready <= (w_state_n != ST_LOADING);
      r_busy  <= (w_state_n == ST_RUN);
      r_step  <= (w_state_n == ST_RUN) && (w_presc_n == w_div_n);
      r_done  <= w_done_n;

      if (w_accept && (w_op == OP_WR_MU)) begin
        r_mu <= N'(w_data);
      end
      if (w_accept && (w_op == OP_WR_ICX)) begin
        r_icx <= N'(w_data);
      end
      if (w_accept && (w_op == OP_WR_ICY)) begin
        r_icy <= N'(w_data);
      end
      if (w_snap_n) begin
        r_x_snap <= x;
        r_y_snap <= y;
      end
    end
  end

  assign cmd.cmd_ready = r_ready;
  assign mu            = r_mu;
  assign icx           = r_icx;
  assign icy           = r_icy;
  assign dda_load      = r_load;
  assign dda_step      = r_step;
  assign x_snap        = r_x_snap;
  assign y_snap        = r_y_snap;
  assign busy          = r_busy;
  assign done          = r_done;
  assign steps_left    = r_left;

endmodule

// File: tb/tb_dda_run_ctrl.sv
// Bench for dda_run_ctrl: directed vector table, directed multi-cycle
// sequences and random commands against a cycle-level reference model.
module tb_dda_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] x, y;
  logic [15:0] mu, icx, icy, x_snap, y_snap;
  logic        dda_load, dda_step, busy, done;
  logic [11:0] steps_left;

  dda_run_ctrl_if cmd_if();

  dda_run_ctrl #(.N(16), .CNT_W(12), .DIV_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd_if),
    .x          (x),
    .y          (y),
    .mu         (mu),
    .icx        (icx),
    .icy        (icy),
    .dda_load   (dda_load),
    .dda_step   (dda_step),
    .x_snap     (x_snap),
    .y_snap     (y_snap),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int step_q[$];
  int done_q[$];

  // ---------------- checking helpers ----------------
  function automatic logic [96:0] dut_bus();
    return {cmd_if.cmd_ready, dda_load, dda_step, busy, done, steps_left,
            mu, icx, icy, x_snap, y_snap};
  endfunction

  task automatic check_bus(input string name, input logic [96:0] act, input logic [96:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 load pulse cycle, 2 running
  int          m_mode, m_presc, m_left, m_div;
  bit          m_done;
  logic [15:0] m_mu, m_icx, m_icy, m_xs, m_ys;

  function automatic logic [96:0] model_bus();
    logic st;
    st = (m_mode == 2) && (m_presc == m_div);
    return {(m_mode != 1), (m_mode == 1), st, (m_mode == 2), m_done,
            12'(m_left), m_mu, m_icx, m_icy, m_xs, m_ys};
  endfunction

  function automatic void model_edge(input logic v, input logic [31:0] w, input logic r,
                                     input logic [15:0] xi, input logic [15:0] yi);
    int  nmode, npresc, nleft;
    bit  ndone, stepping, finishing, acc;
    logic [3:0]  op;
    logic [15:0] d;
    if (!r) begin
      m_mode = 0; m_presc = 0; m_left = 0; m_div = 0; m_done = 0;
      m_mu = 16'h3000; m_icx = 16'h3000; m_icy = 16'h3000;
      m_xs = 16'h0; m_ys = 16'h0;
      return;
    end
    acc       = v && (m_mode != 1);
    op        = w[31:28];
    d         = w[15:0];
    stepping  = (m_mode == 2) && (m_presc == m_div);
    finishing = stepping && (m_left == 1);
    nmode = m_mode; npresc = m_presc; nleft = m_left; ndone = 0;
    if (m_mode == 1) nmode = 0;
    if (m_mode == 2) begin
      npresc = stepping ? 0 : (m_presc + 1) % 65536;
      if (stepping && m_left > 0) nleft = m_left - 1;
      if (finishing) begin nmode = 0; ndone = 1; end
    end
    if (acc) begin
      case (op)
        4'h1: m_mu  = d;
        4'h2: m_icx = d;
        4'h3: m_icy = d;
        4'h4: if (m_mode == 0) nmode = 1;
        4'h5: begin nmode = 2; npresc = 0; nleft = int'(w[27:16]); ndone = 0; end
        4'h6: if (m_mode == 2 && !finishing) begin nmode = 0; npresc = 0; nleft = 0; end
        4'h7: m_div = int'(d);
        4'h8: begin m_xs = xi; m_ys = yi; end
        default: ;
      endcase
    end
    if (ndone) begin m_xs = xi; m_ys = yi; end
    m_mode = nmode; m_presc = npresc; m_left = nleft; m_done = ndone;
  endfunction

  // One model-checked clock cycle with random x/y.
  task automatic tick(input logic v, input logic [31:0] w, input logic r);
    logic [15:0] xi, yi;
    xi = 16'($urandom);
    yi = 16'($urandom);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_word  = w;
    rst_n = r;
    x = xi;
    y = yi;
    model_edge(v, w, r, xi, yi);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_bus("model", dut_bus(), model_bus());
    if (dda_step === 1'b1) step_q.push_back(cyc);
    if (done === 1'b1) done_q.push_back(cyc);
  endtask

  task automatic idle();
    tick(1'b0, 32'h0, 1'b1);
  endtask

  task automatic send(input logic [31:0] w);
    tick(1'b1, w, 1'b1);
  endtask

  function automatic logic [31:0] run_cmd(input int k);
    return {4'h5, 12'(k), 16'h0};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rstn;
    logic        v;
    logic [31:0] w;
    logic [15:0] xi, yi;
    logic        rdy, ld, st, bz, dn;
    logic [11:0] left;
    logic [15:0] emu, eicx, eicy, exs, eys;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rstn, input logic v, input logic [31:0] w,
                     input logic [15:0] xi, input logic [15:0] yi,
                     input logic rdy, input logic ld, input logic st, input logic bz,
                     input logic dn, input logic [11:0] left,
                     input logic [15:0] emu, input logic [15:0] eicx, input logic [15:0] eicy,
                     input logic [15:0] exs, input logic [15:0] eys);
    vec_t t;
    t.rstn = rstn; t.v = v; t.w = w; t.xi = xi; t.yi = yi;
    t.rdy = rdy; t.ld = ld; t.st = st; t.bz = bz; t.dn = dn; t.left = left;
    t.emu = emu; t.eicx = eicx; t.eicy = eicy; t.exs = exs; t.eys = eys;
    tbl.push_back(t);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int          r, op, k;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_word  = 32'h0;
    rst_n = 1'b0;
    x = 16'h0;
    y = 16'h0;

    // rstn v word x y | rdy ld st bz dn left | mu icx icy xs ys
    add(0,0,32'h0000_0000,16'h1111,16'h2222, 1,0,0,0,0,0, 16'h3000,16'h3000,16'h3000,16'h0000,16'h0000);
    add(1,1,32'h2000_2800,16'h1111,16'h2222, 1,0,0,0,0,0, 16'h3000,16'h2800,16'h3000,16'h0000,16'h0000);
    add(1,1,32'h3000_3800,16'h1111,16'h2222, 1,0,0,0,0,0, 16'h3000,16'h2800,16'h3800,16'h0000,16'h0000);
    add(1,1,32'h4000_0000,16'h1111,16'h2222, 0,1,0,0,0,0, 16'h3000,16'h2800,16'h3800,16'h0000,16'h0000);
    add(1,1,32'h1000_1234,16'h1111,16'h2222, 1,0,0,0,0,0, 16'h3000,16'h2800,16'h3800,16'h0000,16'h0000);
    add(1,1,32'h7000_0003,16'h1111,16'h2222, 1,0,0,0,0,0, 16'h3000,16'h2800,16'h3800,16'h0000,16'h0000);
    add(1,1,32'h5002_0000,16'h1111,16'h2222, 1,0,0,1,0,2, 16'h3000,16'h2800,16'h3800,16'h0000,16'h0000);
    add(1,0,32'h0000_0000,16'h1111,16'h2222, 1,0,0,1,0,2, 16'h3000,16'h2800,16'h3800,16'h0000,16'h0000);
    add(1,0,32'h0000_0000,16'h1111,16'h2222, 1,0,0,1,0,2, 16'h3000,16'h2800,16'h3800,16'h0000,16'h0000);
    add(1,0,32'h0000_0000,16'h1111,16'h2222, 1,0,1,1,0,2, 16'h3000,16'h2800,16'h3800,16'h0000,16'h0000);
    add(1,0,32'h0000_0000,16'h1111,16'h2222, 1,0,0,1,0,1, 16'h3000,16'h2800,16'h3800,16'h0000,16'h0000);
    add(1,0,32'h0000_0000,16'h1111,16'h2222, 1,0,0,1,0,1, 16'h3000,16'h2800,16'h3800,16'h0000,16'h0000);
    add(1,0,32'h0000_0000,16'h1111,16'h2222, 1,0,0,1,0,1, 16'h3000,16'h2800,16'h3800,16'h0000,16'h0000);
    add(1,0,32'h0000_0000,16'h1111,16'h2222, 1,0,1,1,0,1, 16'h3000,16'h2800,16'h3800,16'h0000,16'h0000);
    add(1,0,32'h0000_0000,16'h1111,16'h2222, 1,0,0,0,1,0, 16'h3000,16'h2800,16'h3800,16'h1111,16'h2222);
    add(1,0,32'h0000_0000,16'h1111,16'h2222, 1,0,0,0,0,0, 16'h3000,16'h2800,16'h3800,16'h1111,16'h2222);
    add(1,1,32'h8000_0000,16'hAAAA,16'h5555, 1,0,0,0,0,0, 16'h3000,16'h2800,16'h3800,16'hAAAA,16'h5555);
    add(1,1,32'h7000_0000,16'hAAAA,16'h5555, 1,0,0,0,0,0, 16'h3000,16'h2800,16'h3800,16'hAAAA,16'h5555);
    add(1,1,32'h5000_0000,16'hAAAA,16'h5555, 1,0,1,1,0,0, 16'h3000,16'h2800,16'h3800,16'hAAAA,16'h5555);
    add(1,1,32'h4000_0000,16'hAAAA,16'h5555, 1,0,1,1,0,0, 16'h3000,16'h2800,16'h3800,16'hAAAA,16'h5555);
    add(1,1,32'h6000_0000,16'hAAAA,16'h5555, 1,0,0,0,0,0, 16'h3000,16'h2800,16'h3800,16'hAAAA,16'h5555);
    add(1,0,32'h0000_0000,16'hAAAA,16'h5555, 1,0,0,0,0,0, 16'h3000,16'h2800,16'h3800,16'hAAAA,16'h5555);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rstn;
      cmd_if.cmd_valid = tbl[i].v;
      cmd_if.cmd_word  = tbl[i].w;
      x = tbl[i].xi;
      y = tbl[i].yi;
      @(posedge clk);
      @(negedge clk);
      check_bus($sformatf("table[%0d]", i), dut_bus(),
                {tbl[i].rdy, tbl[i].ld, tbl[i].st, tbl[i].bz, tbl[i].dn, tbl[i].left,
                 tbl[i].emu, tbl[i].eicx, tbl[i].eicy, tbl[i].exs, tbl[i].eys});
    end

    // Bounded run, div=3, K=5: step timing and completion.
    tick(1'b0, 32'h0, 1'b0);
    send(32'h7000_0003);
    step_q.delete(); done_q.delete();
    send(run_cmd(5));
    k = cyc;
    for (int i = 0; i < 60 && done_q.size() == 0; i++) idle();
    check_int("bounded_steps", step_q.size(), 5);
    check_int("bounded_done_count", done_q.size(), 1);
    if (step_q.size() == 5 && done_q.size() == 1) begin
      check_int("first_step_offset", step_q[0] - k, 3);
      for (int i = 1; i < 5; i++) check_int("step_spacing", step_q[i] - step_q[i-1], 4);
      check_int("done_after_last", done_q[0] - step_q[4], 1);
    end

    // Free run at div=0, then STOP.
    send(32'h7000_0000);
    send(run_cmd(0));
    step_q.delete(); done_q.delete();
    repeat (100) idle();
    check_int("free_run_steps", step_q.size(), 100);
    send(32'h6000_0000);
    step_q.delete();
    repeat (10) idle();
    check_int("after_stop_steps", step_q.size(), 0);
    check_int("after_stop_done", done_q.size(), 0);
    check_int("after_stop_left", int'(steps_left), 0);

    // mu write mid-run, then restart with K=2.
    send(32'h7000_0001);
    step_q.delete(); done_q.delete();
    send(run_cmd(10));
    for (int i = 0; i < 40 && step_q.size() < 3; i++) idle();
    send(32'h1000_3400);
    check_int("mu_update", int'(mu), 16'h3400);
    send(run_cmd(2));
    for (int i = 0; i < 40 && done_q.size() == 0; i++) idle();
    check_int("restart_total_steps", step_q.size(), 5);
    check_int("restart_done_count", done_q.size(), 1);

    // Reset in the middle of a long run.
    send(32'h7000_0000);
    step_q.delete(); done_q.delete();
    send(run_cmd(100));
    for (int i = 0; i < 40 && step_q.size() < 20; i++) idle();
    tick(1'b0, 32'h0, 1'b0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_mu", int'(mu), 16'h3000);
    step_q.delete();
    repeat (20) idle();
    check_int("reset_no_steps", step_q.size(), 0);
    check_int("reset_no_done", done_q.size(), 0);

    // STOP in the cycle of the final step: completion still reported.
    send(32'h7000_0002);
    step_q.delete(); done_q.delete();
    send(run_cmd(1));
    for (int i = 0; i < 20 && step_q.size() == 0; i++) idle();
    send(32'h6000_0000);
    check_int("stop_on_last_done", int'(done), 1);

    // Lowering div below the running prescaler wraps instead of stepping.
    send(32'h7000_0005);
    send(run_cmd(0));
    repeat (3) idle();
    step_q.delete();
    send(32'h7000_0002);
    repeat (20) idle();
    check_int("div_wrap_no_step", step_q.size(), 0);
    send(32'h6000_0000);

    // Random commands against the model.
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 399);
      if (r == 0) begin
        tick(1'b0, 32'h0, 1'b0);
      end else if (r < 200) begin
        idle();
      end else begin
        op = $urandom_range(0, 15);
        w  = {4'(op), 12'($urandom), 16'($urandom)};
        if (op == 5) begin
          k = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
          w[27:16] = 12'(k);
        end
        if (op == 7) w[15:0] = 16'($urandom_range(0, 4));
        send(w);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
